// File: rtl/seven_seg_scan_driver_if.sv
// Bus between the arithmetic datapath (master) and the scan driver (slave).
// Handshake: none. The master holds digits/dp/blank/lzs_en as plain level
// signals. The driver samples them once per frame, on the last cycle of the
// last slot, so the master may change them at any time without tearing.
// anode/segs/dp_n/frame_tick are registered outputs of the driver.
interface seven_seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dp;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    lzs_en;
   logic [NUM_DIGITS-1:0]   anode;
   logic [6:0]              segs;
   logic                    dp_n;
   logic                    frame_tick;

   modport master (
      output digits, dp, blank, lzs_en,
      input  anode, segs, dp_n, frame_tick
   );

   modport slave (
      input  digits, dp, blank, lzs_en,
      output anode, segs, dp_n, frame_tick
   );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Self-scanning multiplexed seven-segment driver. One slot per digit, each
// slot starts with a dark guard interval (anti-ghosting) then lights the
// digit. Inputs are captured once per frame into snapshot registers; all
// decode works on the snapshot. Outputs are registered (one cycle latency).
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 1000
) (
   input logic                    clk,
   input logic                    reset,
   seven_seg_scan_driver_if.slave bus
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   // Active-low GFEDCBA pattern for one hex nibble.
   function automatic logic [6:0] hex_to_segs(input logic [3:0] h);
      logic [6:0] s;
      s = 7'b1111111;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [CW-1:0]           div_cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] snap_digits;
   logic [NUM_DIGITS-1:0]   snap_dp;
   logic [NUM_DIGITS-1:0]   snap_blank;
   logic                    snap_lzs;

   logic                    slot_end;
   logic                    frame_end;
   logic                    in_guard;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    zero_above;
   logic [3:0]              cur_nib;
   logic                    cur_dark;
   logic                    cur_dp;
   logic [NUM_DIGITS-1:0]   anode_next;
   logic [6:0]              segs_next;
   logic                    dp_n_next;

   logic [NUM_DIGITS-1:0]   anode_q;
   logic [6:0]              segs_q;
   logic                    dp_n_q;
   logic                    frame_tick_q;

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);
   assign in_guard  = (div_cnt < GUARD_END);

   // Refresh divider and digit slot index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (slot_end) begin
         div_cnt <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Snapshot of the inputs, refreshed only at the end of the last slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_digits <= '0;
         snap_dp     <= '0;
         snap_blank  <= '1;
         snap_lzs    <= 1'b0;
      end else if (frame_end) begin
         snap_digits <= bus.digits;
         snap_dp     <= bus.dp;
         snap_blank  <= bus.blank;
         snap_lzs    <= bus.lzs_en;
      end
   end

   // Decode the current slot: leading-zero mask, selected digit, drive values.
   always_comb begin
      lz_mask    = '0;
      zero_above = 1'b1;
      cur_nib    = 4'h0;
      cur_dark   = 1'b1;
      cur_dp     = 1'b0;
      anode_next = '1;
      segs_next  = 7'h7F;
      dp_n_next  = 1'b1;
      // Walk from the most significant digit down; digit 0 is never suppressed.
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above & (snap_digits[4*k +: 4] == 4'h0);
         lz_mask[k] = snap_lzs & zero_above & (k != 0);
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (int'(idx) == k) begin
            cur_nib  = snap_digits[4*k +: 4];
            cur_dark = snap_blank[k] | lz_mask[k];
            cur_dp   = snap_dp[k];
         end
      end
      if (!in_guard && !cur_dark) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(idx) == k) anode_next[k] = 1'b0;
         end
         segs_next = hex_to_segs(cur_nib);
         dp_n_next = ~cur_dp;
      end
   end

   // Output registers; the tick marks the first cycle of a fresh snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anode_q      <= '1;
         segs_q       <= 7'h7F;
         dp_n_q       <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         anode_q      <= anode_next;
         segs_q       <= segs_next;
         dp_n_q       <= dp_n_next;
         frame_tick_q <= frame_end;
      end
   end

   assign bus.anode      = anode_q;
   assign bus.segs       = segs_q;
   assign bus.dp_n       = dp_n_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=8,
// GUARD_CYCLES=2. Expected output tuples {frame_tick, anode, segs, dp_n} are
// queued per frame from a hand-written vector table and compared each cycle.
module tb_seven_seg_scan_driver;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int GC = 2;
   localparam int FRAME = ND * RD;
   localparam logic [12:0] DARK = {1'b0, 4'b1111, 7'h7F, 1'b1};

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic        lzs;
      logic [3:0]  lit;   // slots that must light during DRIVE
      logic [27:0] segs;  // {slot3, slot2, slot1, slot0}
      logic [3:0]  dpn;   // dp_n per lit slot
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic [12:0] exp_q[$];
   vec_t vecs[11];
   vec_t v_ones;

   seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_scan_driver #(
      .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // Clock.
   always #5 clk = ~clk;

   // At most one anode may be low in any cycle.
   always @(negedge clk) begin
      n_tests++;
      if ($countones(~bus.anode) > 1) begin
         n_fail++;
         $display("FAIL anode_onehot: anode=%b, required at most one low bit", bus.anode);
      end
   end

   function automatic vec_t mk(input logic [15:0] d, input logic [3:0] dp,
                               input logic [3:0] bl, input logic lz,
                               input logic [3:0] lit, input logic [27:0] sg,
                               input logic [3:0] dpn);
      vec_t v;
      v.digits = d; v.dp = dp; v.blank = bl; v.lzs = lz;
      v.lit = lit; v.segs = sg; v.dpn = dpn;
      return v;
   endfunction

   function automatic logic [12:0] got_tuple();
      return {bus.frame_tick, bus.anode, bus.segs, bus.dp_n};
   endfunction

   task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got tick=%b anode=%b segs=%b dp_n=%b, required tick=%b anode=%b segs=%b dp_n=%b",
                  name, got[12], got[11:8], got[7:1], got[0], exp[12], exp[11:8], exp[7:1], exp[0]);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.digits = v.digits;
      bus.dp     = v.dp;
      bus.blank  = v.blank;
      bus.lzs_en = v.lzs;
   endtask

   // Queue the 32 output cycles that follow a frame_tick for snapshot v.
   task automatic push_frame(input vec_t v);
      logic [3:0] an;
      for (int s = 0; s < ND; s++) begin
         for (int c = 1; c <= RD; c++) begin
            logic [12:0] e;
            int off;
            off = s * RD + c;
            if (c <= GC || !v.lit[s]) begin
               e = DARK;
            end else begin
               an = 4'b1111;
               an[s] = 1'b0;
               e = {1'b0, an, v.segs[7*s +: 7], v.dpn[s]};
            end
            e[12] = (off == FRAME);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic check_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expected queue empty", tag);
         end else begin
            check(tag, got_tuple(), exp_q.pop_front());
         end
      end
   endtask

   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
         @(negedge clk);
         seen = bus.frame_tick;
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL wait_tick: frame_tick=0 after %0d cycles, required 1", 3 * FRAME);
      end
   endtask

   // Call at the negedge where reset drops: dark for 32 cycles, tick at 32.
   task automatic check_restart(input string tag);
      #1 check({tag, "_release"}, got_tuple(), DARK);
      for (int k = 1; k <= FRAME; k++) begin
         logic [12:0] e;
         @(negedge clk);
         e = DARK;
         e[12] = (k == FRAME);
         check(tag, got_tuple(), e);
      end
   endtask

   // New inputs at a tick: the next frame still shows prev, then v.
   task automatic apply_vec(input vec_t v, input vec_t prev, input bit have_prev, input string tag);
      drive(v);
      if (have_prev) begin
         push_frame(prev);
         check_cycles(FRAME, {tag, "_hold"});
      end else begin
         wait_tick();
      end
      push_frame(v);
      check_cycles(FRAME, tag);
   endtask

   initial begin
      vecs[0]  = mk(16'h3A5F, 4'b0000, 4'b0000, 1'b0, 4'b1111,
                    {7'b0110000, 7'b0001000, 7'b0010010, 7'b0001110}, 4'b1111);
      vecs[1]  = mk(16'h0030, 4'b0000, 4'b0000, 1'b1, 4'b0011,
                    {7'h7F, 7'h7F, 7'b0110000, 7'b1000000}, 4'b1111);
      vecs[2]  = mk(16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b0001,
                    {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111);
      vecs[3]  = mk(16'h3A5F, 4'b0100, 4'b0010, 1'b0, 4'b1101,
                    {7'b0110000, 7'b0001000, 7'h7F, 7'b0001110}, 4'b1011);
      vecs[4]  = mk(16'h0105, 4'b0000, 4'b0000, 1'b1, 4'b0111,
                    {7'h7F, 7'b1111001, 7'b1000000, 7'b0010010}, 4'b1111);
      vecs[5]  = mk(16'h8000, 4'b0000, 4'b0000, 1'b1, 4'b1111,
                    {7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111);
      vecs[6]  = mk(16'h0000, 4'b1001, 4'b0001, 1'b1, 4'b0000,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111);
      vecs[7]  = mk(16'hEDCB, 4'b1111, 4'b0000, 1'b0, 4'b1111,
                    {7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011}, 4'b0000);
      vecs[8]  = mk(16'h9876, 4'b0000, 4'b0000, 1'b1, 4'b1111,
                    {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}, 4'b1111);
      vecs[9]  = mk(16'h4210, 4'b0000, 4'b0000, 1'b0, 4'b1111,
                    {7'b0011001, 7'b0100100, 7'b1111001, 7'b1000000}, 4'b1111);
      vecs[10] = mk(16'h0000, 4'b0000, 4'b0000, 1'b0, 4'b1111,
                    {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111);
      v_ones   = mk(16'h1111, 4'b0000, 4'b0000, 1'b0, 4'b1111,
                    {7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001}, 4'b1111);

      // Reset held with random inputs, then released.
      bus.digits = 16'($urandom);
      bus.dp     = 4'($urandom_range(0, 15));
      bus.blank  = 4'($urandom_range(0, 15));
      bus.lzs_en = 1'($urandom_range(0, 1));
      #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("in_reset", got_tuple(), DARK);
      end
      reset = 1'b0;
      check_restart("post_reset");

      // Table-driven vectors, each applied at a frame tick.
      for (int i = 0; i < 11; i++) begin
         apply_vec(vecs[i], (i > 0) ? vecs[i-1] : vecs[0], i > 0, $sformatf("vec%0d", i));
      end

      // Tear-free update: new digits during slot 2 appear only next frame.
      apply_vec(vecs[0], vecs[10], 1'b1, "scan");
      push_frame(vecs[0]);
      check_cycles(20, "tear_before");
      bus.digits = 16'h1111;
      check_cycles(FRAME - 20, "tear_after");
      push_frame(v_ones);
      check_cycles(FRAME, "tear_next");

      // Asynchronous reset during slot 2 DRIVE.
      push_frame(v_ones);
      check_cycles(2 * RD + GC + 1, "pre_reset");
      exp_q.delete();
      #2 reset = 1'b1;
      #1 check("async_reset", got_tuple(), DARK);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_reset", got_tuple(), DARK);
      end
      reset = 1'b0;
      check_restart("restart");
      push_frame(v_ones);
      check_cycles(FRAME, "resume");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
